// File: rtl/dav_l1a_match_pkg.sv
// dav_l1a_match_pkg: shared defaults and helpers for the DAV/L1A matcher
package dav_l1a_match_pkg;
    localparam int N_SRC_D = 5;
    localparam int LAT_D = 24;
    localparam int WIN_D = 16;
    localparam int MCW = 16;
    typedef logic [MCW-1:0] mcnt_t;
    function automatic mcnt_t sat_inc(input mcnt_t v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/dav_l1a_match_fifo.sv
// dav_l1a_match_fifo: DEPTH x TSW timestamp FIFO holding outstanding L1As
module dav_l1a_match_fifo #(
    parameter int DEPTH = 8,
    parameter int TSW = 12
) (
    input  logic           C,
    input  logic           RST,
    input  logic           push,
    input  logic           pop,
    input  logic [TSW-1:0] din,
    output logic [TSW-1:0] head,
    output logic           empty,
    output logic           full
);
    localparam int AW = $clog2(DEPTH);
    logic [TSW-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head = mem[rp[AW-1:0]];
    always_ff @(posedge C) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
    always_ff @(posedge C) begin
        if (RST) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/dav_l1a_match.sv
// dav_l1a_match: matches enabled DAV rises against L1A windows and reports
// per-L1A present/missing sources, spurious DAVs and a saturating miss count
module dav_l1a_match
    import dav_l1a_match_pkg::*;
#(
    parameter int N_SRC = N_SRC_D,
    parameter int DEPTH = 8,
    parameter int TSW = 12,
    parameter int LAT = LAT_D,
    parameter int WIN = WIN_D,
    parameter int CRW = 3
) (
    input  logic             C,
    input  logic             RST,
    input  logic             L1A,
    input  logic [N_SRC-1:0] DAV,
    input  logic [N_SRC-1:0] DAV_EN,
    output logic             RSLT_VLD,
    output logic [N_SRC-1:0] RSLT_DAV,
    output logic [N_SRC-1:0] RSLT_MISS,
    output logic [N_SRC-1:0] SPUR,
    output logic             OVFL,
    output logic [MCW-1:0]   MISS_CNT
);
    localparam logic [TSW-1:0] AGE = TSW'(LAT + WIN);
    localparam logic [CRW-1:0] MAXC = {CRW{1'b1}};
    logic [TSW-1:0] ts, head_ts;
    logic [N_SRC-1:0] dav_q, rise, hit, spur_n;
    logic [CRW-1:0] credit [N_SRC];
    logic [CRW-1:0] crd_n [N_SRC];
    logic empty, full, exp_now;
    assign rise = DAV & ~dav_q & DAV_EN;
    assign exp_now = !empty && (ts - head_ts) == AGE;
    dav_l1a_match_fifo #(.DEPTH(DEPTH), .TSW(TSW)) u_fifo (
        .C(C),
        .RST(RST),
        .push(L1A),
        .pop(exp_now),
        .din(ts),
        .head(head_ts),
        .empty(empty),
        .full(full)
    );
    // A rise during expiry belongs to the expiring L1A, so it neither adds credit nor flags spurious
    always_comb begin
        hit = '0;
        spur_n = '0;
        crd_n = credit;
        for (int i = 0; i < N_SRC; i++) begin
            hit[i] = DAV_EN[i] & ((credit[i] != '0) | rise[i]);
            spur_n[i] = rise[i] & ~exp_now & (empty | (credit[i] == MAXC));
            crd_n[i] = !DAV_EN[i] ? '0
                     : exp_now ? credit[i] - CRW'(credit[i] != '0)
                     : (rise[i] && !empty && credit[i] != MAXC) ? credit[i] + 1'b1
                     : credit[i];
        end
    end
    always_ff @(posedge C) begin
        if (RST) begin
            ts <= '0;
            dav_q <= '0;
            for (int i = 0; i < N_SRC; i++) credit[i] <= '0;
            RSLT_VLD <= 1'b0;
            RSLT_DAV <= '0;
            RSLT_MISS <= '0;
            SPUR <= '0;
            OVFL <= 1'b0;
            MISS_CNT <= '0;
        end else begin
            ts <= ts + 1'b1;
            dav_q <= DAV;
            credit <= crd_n;
            RSLT_VLD <= exp_now;
            RSLT_DAV <= exp_now ? hit : '0;
            RSLT_MISS <= exp_now ? DAV_EN & ~hit : '0;
            SPUR <= spur_n;
            if (L1A && full) OVFL <= 1'b1;
            if (exp_now && |(DAV_EN & ~hit)) MISS_CNT <= sat_inc(MISS_CNT);
        end
    end
endmodule

// File: tb/tb_dav_l1a_match.sv
// tb_dav_l1a_match: directed stimulus with a queue-based reference model
// checked every cycle, plus hand-computed checkpoints
module tb_dav_l1a_match;
    localparam int LW = 40;
    logic clk = 1'b0;
    logic RST, L1A;
    logic [4:0] DAV, DAV_EN;
    logic RSLT_VLD, OVFL;
    logic [4:0] RSLT_DAV, RSLT_MISS, SPUR;
    logic [15:0] MISS_CNT;
    int total = 0;
    int bad = 0;
    int q[$];
    int cr[5];
    int cyc;
    logic [4:0] dq_m, ed, em, es;
    logic ev, eo;
    logic [15:0] emc;
    bit armed = 0;

    dav_l1a_match dut (
        .C(clk), .RST(RST), .L1A(L1A), .DAV(DAV), .DAV_EN(DAV_EN),
        .RSLT_VLD(RSLT_VLD), .RSLT_DAV(RSLT_DAV), .RSLT_MISS(RSLT_MISS),
        .SPUR(SPUR), .OVFL(OVFL), .MISS_CNT(MISS_CNT)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int n;
        bit x, r;
        if (RST) begin
            q.delete();
            foreach (cr[i]) cr[i] = 0;
            dq_m = '0; cyc = 0; ev = 0; ed = '0; em = '0; es = '0; eo = 0; emc = '0;
            armed = 1;
        end else begin
            n = q.size();
            x = (n > 0) ? (cyc - q[0] == LW) : 1'b0;
            ed = '0;
            es = '0;
            for (int i = 0; i < 5; i++) begin
                r = DAV[i] && !dq_m[i] && DAV_EN[i];
                if (!DAV_EN[i]) cr[i] = 0;
                else if (x) begin
                    ed[i] = (cr[i] > 0) || r;
                    if (cr[i] > 0) cr[i]--;
                end else if (r) begin
                    if (n > 0 && cr[i] < 7) cr[i]++;
                    else es[i] = 1'b1;
                end
            end
            ev = x;
            em = x ? (DAV_EN & ~ed) : 5'h00;
            if (x && em != 0 && emc != 16'hFFFF) emc++;
            if (L1A && n == 8) eo = 1'b1;
            if (x) void'(q.pop_front());
            if (L1A && n < 8) q.push_back(cyc);
            dq_m = DAV;
            cyc++;
        end
    endtask

    task automatic tick(input logic l, input logic [4:0] d, input logic [4:0] e);
        L1A = l;
        DAV = d;
        DAV_EN = e;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            total++;
            if ({RSLT_VLD, RSLT_DAV, RSLT_MISS, SPUR, OVFL, MISS_CNT} !== {ev, ed, em, es, eo, emc}) begin
                bad++;
                $display("FAIL model t=%0t vld=%b/%b dav=%h/%h miss=%h/%h spur=%h/%h ovfl=%b/%b cnt=%0d/%0d (act/req)",
                         $time, RSLT_VLD, ev, RSLT_DAV, ed, RSLT_MISS, em, SPUR, es, OVFL, eo, MISS_CNT, emc);
            end
        end
    end

    initial begin
        int n, first, last;
        RST = 1'b1; L1A = 1'b0; DAV = '0; DAV_EN = '0;
        @(negedge clk);
        tick(0, 0, 0);
        tick(0, 0, 0);
        RST = 1'b0;
        chk("rst_vld", RSLT_VLD, 0);
        chk("rst_ovfl", OVFL, 0);
        chk("rst_cnt", MISS_CNT, 0);
        // all five sources match one L1A
        tick(1, 0, 5'h1F);
        repeat (29) tick(0, 0, 5'h1F);
        repeat (11) tick(0, 5'h1F, 5'h1F);
        chk("t1_vld", RSLT_VLD, 1);
        chk("t1_dav", RSLT_DAV, 5'h1F);
        chk("t1_miss", RSLT_MISS, 0);
        chk("t1_cnt", MISS_CNT, 0);
        tick(0, 0, 5'h1F);
        chk("t1_vld_off", RSLT_VLD, 0);
        // source 2 never rises
        tick(1, 0, 5'h1F);
        repeat (5) tick(0, 0, 5'h1F);
        repeat (35) tick(0, 5'h1B, 5'h1F);
        chk("t2_dav", RSLT_DAV, 5'h1B);
        chk("t2_miss", RSLT_MISS, 5'h04);
        chk("t2_cnt", MISS_CNT, 1);
        tick(0, 0, 5'h1F);
        // rise on empty FIFO is spurious and leaves no credit
        tick(0, 5'h01, 5'h1F);
        chk("t3_spur", SPUR, 5'h01);
        tick(0, 0, 5'h1F);
        chk("t3_spur_off", SPUR, 0);
        tick(1, 0, 5'h1F);
        repeat (40) tick(0, 5'h1E, 5'h1F);
        chk("t3_miss", RSLT_MISS, 5'h01);
        chk("t3_cnt", MISS_CNT, 2);
        tick(0, 0, 5'h1F);
        // disabling source 4 mid-window drops its credit and its miss
        tick(1, 0, 5'h1F);
        repeat (5) tick(0, 5'h1F, 5'h1F);
        repeat (35) tick(0, 5'h1F, 5'h0F);
        chk("en_dav", RSLT_DAV, 5'h0F);
        chk("en_miss", RSLT_MISS, 0);
        tick(0, 0, 5'h1F);
        // overflow: ninth back-to-back L1A dropped
        repeat (9) tick(1, 0, 5'h1F);
        chk("t4_ovfl", OVFL, 1);
        n = 0; first = -1; last = -1;
        for (int k = 0; k < 50; k++) begin
            tick(0, 0, 5'h1F);
            if (RSLT_VLD) begin
                if (first < 0) first = k;
                last = k;
                n++;
            end
        end
        chk("t4_vld_cnt", n, 8);
        chk("t4_vld_span", last - first, 7);
        chk("t4_cnt", MISS_CNT, 10);
        // timestamp wrap: L1A at TS=4090
        RST = 1'b1;
        tick(0, 0, 5'h1F);
        RST = 1'b0;
        repeat (4090) tick(0, 0, 5'h1F);
        tick(1, 0, 5'h1F);
        repeat (15) tick(0, 0, 5'h1F);
        repeat (25) tick(0, 5'h1F, 5'h1F);
        chk("t5_vld", RSLT_VLD, 1);
        chk("t5_dav", RSLT_DAV, 5'h1F);
        chk("t5_ovfl", OVFL, 0);
        tick(0, 0, 5'h1F);
        // reset with three pending L1As
        tick(1, 0, 5'h1F);
        tick(0, 0, 5'h1F);
        tick(1, 0, 5'h1F);
        tick(1, 5'h03, 5'h1F);
        repeat (5) tick(0, 5'h03, 5'h1F);
        RST = 1'b1;
        tick(0, 0, 5'h1F);
        tick(0, 0, 5'h1F);
        RST = 1'b0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            tick(0, 0, 5'h1F);
            if (RSLT_VLD) n++;
        end
        chk("t6_no_vld", n, 0);
        chk("t6_cnt", MISS_CNT, 0);
        tick(1, 0, 5'h1F);
        repeat (40) tick(0, 5'h1F, 5'h1F);
        chk("t6_vld", RSLT_VLD, 1);
        chk("t6_dav", RSLT_DAV, 5'h1F);
        tick(0, 0, 5'h1F);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
